vip_frame_sequencer: RTL and testbench
======================================

Name: vip_frame_sequencer

Overview:
Controller between the vip_top input FIFO and the processing core. Latches the frame geometry (width, height, num_frame) on a start pulse, then drains pixels from the show-ahead input FIFO. Each pixel goes to the core on a valid/ready stream tagged with x/y coordinates and sof/eol/eof markers. It signals done once the programmed number of frames has been transferred.

Parameters:
DWIDTH, 24, pixel data width (RGB888)
CWIDTH, 11, width of the geometry and coordinate fields; matches the width/height/num_frame buses

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches geometry and begins a job; honoured only in IDLE
abort  in  1  synchronous job cancel
width  in  CWIDTH  pixels per line
height  in  CWIDTH  lines per frame
num_frame  in  CWIDTH  frames per job
fifo_in_data  in  DWIDTH  FIFO head word (show-ahead: valid whenever fifo_in_empty=0)
fifo_in_empty  in  1  FIFO empty
fifo_in_rdreq  out  1  pop FIFO head this cycle
pix_data  out  DWIDTH  pixel to core
pix_valid  out  1  pix_* fields valid
pix_ready  in  1  core accepts when pix_valid and pix_ready are both 1
pix_x  out  CWIDTH  column of pix_data
pix_y  out  CWIDTH  line of pix_data
pix_sof  out  1  first pixel of a frame
pix_eol  out  1  last pixel of a line
pix_eof  out  1  last pixel of a frame
frame_idx  out  CWIDTH  index of the frame currently being output
busy  out  1  state is RUN or DRAIN
done  out  1  one-cycle pulse at job completion
cfg_err  out  1  sticky; set by a start with any zero geometry field; cleared by the next start

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs are 0: rdreq, pix_*, frame_idx, busy, done, cfg_err. All counters are 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1:
  - Latch W=width, H=height, F=num_frame. Clear counters x, y, f. Clear cfg_err.
  - If W, H or F is 0: set cfg_err, go to DONE.
  - Otherwise go to RUN.
- start outside IDLE is ignored.
- Output register: single stage. advance = !pix_valid || pix_ready.
- fifo_in_rdreq = (state==RUN) && !fifo_in_empty && advance. Combinational; never asserted while empty.
- On a pop:
  - pix_data <= fifo_in_data; pix_valid <= 1.
  - pix_x <= x; pix_y <= y; frame_idx <= f.
  - pix_sof <= (x==0 && y==0).
  - pix_eol <= (x==W-1).
  - pix_eof <= (x==W-1 && y==H-1).
- If advance=1 and there is no pop: pix_valid <= 0 and all markers <= 0.
- While pix_valid=1 and pix_ready=0, every pix_* output holds stable.
- Latency: FIFO head to pix_valid is 1 cycle. Full throughput: one pixel per cycle when the FIFO is non-empty and pix_ready=1.
- Counter update on a pop, x/y/f all CWIDTH wide:
  - x wraps to 0 at W-1 and increments y.
  - y wraps to 0 at H-1 and increments f.
  - The pop with x=W-1, y=H-1, f=F-1 is the last pop. State moves to DRAIN and no further pops occur.
- DRAIN: wait until the final pixel is accepted (pix_valid && pix_ready), then go to DONE. If the final pixel is accepted in the same cycle it is popped, DRAIN lasts exactly one cycle.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- abort=1 in any state (highest priority, beats start):
  - Next state IDLE. pix_valid and markers clear, rdreq=0, counters clear.
  - done is not pulsed. Pixels left in the FIFO are not flushed; that is the caller's responsibility.
- FIFO empty mid-frame: RUN stalls. pix_valid drops after the pending pixel is accepted. Counters hold.
- width=1: every pixel has pix_eol=1. width=1 and height=1: every pixel has sof, eol and eof all 1.

Test Plan:
1. W=4, H=2, F=2; FIFO preloaded with 16 words; pix_ready=1 -> 16 consecutive valid beats. sof on beats 0 and 8; eol on beats 3, 7, 11, 15; eof on beats 7 and 15; frame_idx = 0 then 1; done pulses 2 cycles after the last pop.
2. Same job with pix_ready toggling 1,0,0,1 -> pix_* held stable while ready=0. No FIFO word is lost or duplicated (sequence-number data 0..15 is checked).
3. FIFO empties after 5 words, refills 10 cycles later -> pix_valid gaps; x/y resume at (1,1); eol/eof positions are unchanged.
4. start with W=0, H=3, F=1 -> cfg_err=1, no rdreq, done pulse on the next cycle; a following start with W=2, H=1, F=1 clears cfg_err.
5. abort asserted together with a pop mid-frame 0 -> next cycle state IDLE, pix_valid=0, busy=0, no done pulse; a new start restarts at x=0, y=0, sof=1.
6. reset driven low while in RUN with pix_valid=1 -> all outputs go to 0 immediately (asynchronous); after release, state is IDLE.

Source files
------------

// File: rtl/vip_frame_sequencer.sv
// Frame sequencer: pops the show-ahead input FIFO and streams pixels to the core.
// Tags each pixel with x/y/frame and sof/eol/eof; done pulses at job end.
module vip_frame_sequencer #(
  parameter int DWIDTH = 24,
  parameter int CWIDTH = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CWIDTH-1:0] width,
  input  logic [CWIDTH-1:0] height,
  input  logic [CWIDTH-1:0] num_frame,
  input  logic [DWIDTH-1:0] fifo_in_data,
  input  logic              fifo_in_empty,
  output logic              fifo_in_rdreq,
  output logic [DWIDTH-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [CWIDTH-1:0] pix_x,
  output logic [CWIDTH-1:0] pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic [CWIDTH-1:0] frame_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CWIDTH-1:0] ONE = CWIDTH'(1);

  state_t state;
  state_t state_nx;

  logic [CWIDTH-1:0] w_q;
  logic [CWIDTH-1:0] h_q;
  logic [CWIDTH-1:0] f_q;
  logic [CWIDTH-1:0] x_q;
  logic [CWIDTH-1:0] y_q;
  logic [CWIDTH-1:0] f_cnt;

  logic advance;
  logic pop;
  logic x_last;
  logic y_last;
  logic f_last;
  logic geo_zero;
  logic go;

  assign advance  = !pix_valid || pix_ready;
  // abort wins over a pop that would otherwise happen this cycle
  assign pop      = (state == S_RUN) && !fifo_in_empty
                  && advance && !abort;
  assign x_last   = (x_q == w_q - ONE);
  assign y_last   = (y_q == h_q - ONE);
  assign f_last   = (f_cnt == f_q - ONE);
  assign geo_zero = (width == '0) || (height == '0)
                  || (num_frame == '0);
  assign go       = (state == S_IDLE) && start;

  assign fifo_in_rdreq = pop;
  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = geo_zero ? S_DONE : S_RUN;
      S_RUN:   if (pop && x_last && y_last && f_last)
                 state_nx = S_DRAIN;
      S_DRAIN: if (pix_valid && pix_ready) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_q       <= '0;
      h_q       <= '0;
      f_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      f_cnt     <= '0;
      cfg_err   <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      frame_idx <= '0;
    end else if (abort) begin
      x_q       <= '0;
      y_q       <= '0;
      f_cnt     <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
    end else begin
      if (go) begin
        w_q     <= width;
        h_q     <= height;
        f_q     <= num_frame;
        x_q     <= '0;
        y_q     <= '0;
        f_cnt   <= '0;
        cfg_err <= geo_zero;
      end
      if (pop) begin
        pix_data  <= fifo_in_data;
        pix_valid <= 1'b1;
        pix_x     <= x_q;
        pix_y     <= y_q;
        frame_idx <= f_cnt;
        pix_sof   <= (x_q == '0) && (y_q == '0);
        pix_eol   <= x_last;
        pix_eof   <= x_last && y_last;
        if (x_last) begin
          x_q <= '0;
          if (y_last) begin
            y_q   <= '0;
            f_cnt <= f_cnt + ONE;
          end else begin
            y_q <= y_q + ONE;
          end
        end else begin
          x_q <= x_q + ONE;
        end
      end else if (advance) begin
        pix_valid <= 1'b0;
        pix_sof   <= 1'b0;
        pix_eol   <= 1'b0;
        pix_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vip_frame_sequencer.sv
// Bench for vip_frame_sequencer: table of jobs plus random jobs,
// checked against an arithmetic model of the accepted pixel stream.
module tb_vip_frame_sequencer;

  localparam int DW = 24;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] width = '0;
  logic [CW-1:0] height = '0;
  logic [CW-1:0] num_frame = '0;
  logic [DW-1:0] fifo_in_data = '0;
  logic          fifo_in_empty = 1'b1;
  logic          fifo_in_rdreq;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic [CW-1:0] frame_idx;
  logic          busy;
  logic          done;
  logic          cfg_err;

  vip_frame_sequencer #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clock(clk), .reset(rst_n), .start(start), .abort(abort),
    .width(width), .height(height), .num_frame(num_frame),
    .fifo_in_data(fifo_in_data), .fifo_in_empty(fifo_in_empty),
    .fifo_in_rdreq(fifo_in_rdreq), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_eof(pix_eof),
    .frame_idx(frame_idx), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w; int h; int f;
    int rmode; int fmode; int err;
  } vec_t;

  vec_t tbl[10];

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sent[$];
  bit  pop_pending = 0;
  bit  model_on = 0;
  int  mw, mh, total, k_acc, done_cnt, job_id;
  int  cyc = 0;
  int  first_acc, last_acc, last_pop, done_cyc;
  logic [63:0] p_pack = '0;
  bit  p_valid = 0, p_ready = 0, p_abort = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] out_pack();
    return {4'b0, pix_data, pix_x, pix_y, frame_idx,
            pix_sof, pix_eol, pix_eof};
  endfunction

  function automatic logic [63:0] exp_pack(input int k);
    int fs, x, y, f, r;
    fs = mw * mh;
    r  = k % fs;
    x  = k % mw;
    y  = (k / mw) % mh;
    f  = k / fs;
    return {4'b0, sent[k], CW'(x), CW'(y), CW'(f),
            r == 0, x == mw - 1, r == fs - 1};
  endfunction

  task automatic observe();
    if (fifo_in_rdreq) begin
      check("rdreq_while_empty", 64'(fifo_in_empty), 64'd0);
      last_pop = cyc;
    end
    if (p_valid && !p_ready && !p_abort && rst_n)
      check("hold_stable", {pix_valid, out_pack()},
            {1'b1, p_pack});
    if (pix_valid && pix_ready && model_on) begin
      if (k_acc < total) check("beat", out_pack(), exp_pack(k_acc));
      else check("extra_beat", 64'(k_acc), 64'(total - 1));
      if (k_acc == 0) first_acc = cyc;
      last_acc = cyc;
      k_acc++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    p_pack  = out_pack();
    p_valid = pix_valid;
    p_ready = pix_ready;
    p_abort = abort;
    pop_pending = fifo_in_rdreq;
  endtask

  task automatic cycle(input bit rdy, input bit st, input bit ab);
    @(posedge clk);
    if (pop_pending && fq.size() > 0) void'(fq.pop_front());
    #1;
    pix_ready = rdy;
    start = st;
    abort = ab;
    fifo_in_empty = (fq.size() == 0);
    fifo_in_data = (fq.size() > 0) ? fq[0] : '0;
    cyc++;
    #1;
    observe();
  endtask

  task automatic push_word(input int i);
    logic [DW-1:0] wd;
    wd = {8'(job_id), 16'(i)};
    fq.push_back(wd);
    sent.push_back(wd);
  endtask

  task automatic setup_model(input int w, input int h, input int f);
    job_id++;
    mw = w; mh = h;
    total = (w == 0 || h == 0 || f == 0) ? 0 : w * h * f;
    sent.delete();
    k_acc = 0; done_cnt = 0;
    first_acc = -1; last_acc = -1; last_pop = -1; done_cyc = -1;
    model_on = 1;
    width = CW'(w); height = CW'(h); num_frame = CW'(f);
  endtask

  task automatic run_job(input vec_t v);
    int pushed, j, st_cyc;
    bit rdy;
    setup_model(v.w, v.h, v.f);
    pushed = 0;
    if (v.fmode == 0)
      while (pushed < total) begin push_word(pushed); pushed++; end
    else if (v.fmode == 1)
      while (pushed < total && pushed < 5) begin
        push_word(pushed); pushed++;
      end
    cycle(1'b0, 1'b1, 1'b0);
    st_cyc = cyc;
    j = 0;
    while (done_cnt == 0 && j < 3000) begin
      case (v.rmode)
        0: rdy = 1'b1;
        1: rdy = (j % 4 == 0) || (j % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (v.fmode == 1 && j == 15)
        while (pushed < total) begin push_word(pushed); pushed++; end
      if (v.fmode == 2 && pushed < total && $urandom_range(0, 1) == 1)
        begin push_word(pushed); pushed++; end
      cycle(rdy, 1'b0, 1'b0);
      if (j == 0) begin
        check("cfg_err", 64'(cfg_err), 64'(v.err));
        if (total > 0) check("busy_run", 64'(busy), 64'd1);
      end
      j++;
    end
    if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
    check("beat_count", 64'(k_acc), 64'(total));
    if (total > 0) begin
      check("done_after_accept", 64'(done_cyc - last_acc), 64'd1);
      if (v.rmode == 0 && v.fmode == 0) begin
        check("done_after_pop", 64'(done_cyc - last_pop), 64'd2);
        check("full_rate", 64'(last_acc - first_acc),
              64'(total - 1));
      end
    end else begin
      check("err_done_lat", 64'(done_cyc - st_cyc), 64'd1);
    end
    cycle(1'b1, 1'b0, 1'b0);
    check("done_pulse_1cyc", {busy, done, cfg_err},
          {2'b00, 1'(v.err)});
    model_on = 0;
  endtask

  task automatic flush();
    fq.delete();
    pop_pending = 0;
    p_valid = 0;
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{4, 2, 2, 0, 0, 0};
    tbl[1] = '{4, 2, 2, 1, 0, 0};
    tbl[2] = '{4, 2, 1, 0, 1, 0};
    tbl[3] = '{0, 3, 1, 0, 0, 1};
    tbl[4] = '{2, 1, 1, 0, 0, 0};
    tbl[5] = '{1, 3, 2, 2, 2, 0};
    tbl[6] = '{1, 1, 3, 2, 2, 0};
    tbl[7] = '{5, 3, 2, 2, 2, 0};
    tbl[8] = '{3, 4, 1, 1, 2, 0};
    tbl[9] = '{2, 2, 0, 0, 0, 1};
    job_id = 0;

    #3;
    check("reset_outputs",
          {fifo_in_rdreq, pix_valid, busy, done, cfg_err, out_pack()},
          65'd0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) run_job(tbl[i]);

    for (int r = 0; r < 6; r++) begin
      v.w = $urandom_range(1, 6);
      v.h = $urandom_range(1, 4);
      v.f = $urandom_range(1, 3);
      v.rmode = $urandom_range(0, 2);
      v.fmode = $urandom_range(0, 2);
      v.err = 0;
      run_job(v);
    end

    // abort together with a would-be pop, mid frame 0
    setup_model(4, 2, 1);
    for (int i = 0; i < 8; i++) push_word(i);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check("abort_no_rdreq", 64'(fifo_in_rdreq), 64'd0);
    cycle(1'b1, 1'b0, 1'b0);
    check("abort_idle",
          {fifo_in_rdreq, pix_valid, busy, done,
           pix_sof, pix_eol, pix_eof}, 64'd0);
    cycle(1'b1, 1'b0, 1'b0);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    model_on = 0;
    flush();
    run_job(tbl[2]);

    // asynchronous reset in RUN with a pixel held
    setup_model(4, 2, 1);
    for (int i = 0; i < 8; i++) push_word(i);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("pre_reset_valid", {pix_valid, busy}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset",
          {fifo_in_rdreq, pix_valid, busy, done, cfg_err, out_pack()},
          65'd0);
    model_on = 0;
    flush();
    cycle(1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    check("post_reset_idle", {fifo_in_rdreq, pix_valid, busy, done},
          4'd0);
    run_job(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
